vga_tile_engine: RTL and testbench

//  Parametrised VGA timing generator and tile-bitmap renderer; next generation of the fixed 640x480 grid display.

---
 rtl/vga_tile_engine_pkg.sv | 38 +++
 rtl/vga_tile_engine_timing_gen.sv | 71 +++++++
 rtl/vga_tile_engine.sv | 213 +++++++++++++++++++++
 tb/tb_vga_tile_engine.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_tile_engine_pkg.sv
// Shared timing defaults, state encoding and the video flag bundle
// for the VGA tile engine and its timing generator.
package vga_tile_engine_pkg;

  localparam int DEF_PIXEL_DIV = 2;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FPORCH  = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BPORCH  = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FPORCH  = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BPORCH  = 33;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } wr_state_t;

  typedef struct packed {
    logic pix_en;
    logic h_last;
    logic v_last;
    logic active;
    logic hs_act;
    logic vs_act;
  } vid_t;

  function automatic int total(
    input int a,
    input int b,
    input int c,
    input int d
  );
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/vga_tile_engine_timing_gen.sv
// Pixel-enable divider, h/v counters, sync/active flags and frame pulse.
// Flags are combinational from the counters; the consumer registers them.
module vga_tile_engine_timing_gen
  import vga_tile_engine_pkg::*;
#(
  parameter int PIXEL_DIV = DEF_PIXEL_DIV,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FPORCH  = DEF_H_FPORCH,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BPORCH  = DEF_H_BPORCH,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FPORCH  = DEF_V_FPORCH,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BPORCH  = DEF_V_BPORCH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output vid_t o_vid,
  output logic o_frame
);

  localparam int H_TOTAL =
    total(H_ACTIVE, H_FPORCH, H_SYNC, H_BPORCH);
  localparam int V_TOTAL =
    total(V_ACTIVE, V_FPORCH, V_SYNC, V_BPORCH);
  localparam int DW  = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int HS0 = H_ACTIVE + H_FPORCH;
  localparam int HS1 = HS0 + H_SYNC;
  localparam int VS0 = V_ACTIVE + V_FPORCH;
  localparam int VS1 = VS0 + V_SYNC;

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_frame;
  logic          w_pix_en;
  logic          w_h_last;
  logic          w_v_last;

  assign w_pix_en = (r_div == '0);
  assign w_h_last = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v == VW'(V_TOTAL - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= 1'b0;
    end else begin
      r_div   <= (r_div == DW'(PIXEL_DIV - 1)) ? '0 : r_div + 1'b1;
      r_frame <= w_pix_en & w_h_last & w_v_last;
      if (w_pix_en) begin
        r_h <= w_h_last ? '0 : r_h + 1'b1;
        if (w_h_last)
          r_v <= w_v_last ? '0 : r_v + 1'b1;
      end
    end
  end

  assign o_vid.pix_en = w_pix_en;
  assign o_vid.h_last = w_h_last;
  assign o_vid.v_last = w_v_last;
  assign o_vid.active = (32'(r_h) < H_ACTIVE) && (32'(r_v) < V_ACTIVE);
  assign o_vid.hs_act = (32'(r_h) >= HS0) && (32'(r_h) < HS1);
  assign o_vid.vs_act = (32'(r_v) >= VS0) && (32'(r_v) < VS1);
  assign o_frame      = r_frame;

endmodule

// File: rtl/vga_tile_engine.sv
// Tile-bitmap VGA renderer: tile map with write/shift/clear port,
// cursor outline and registered colour/sync outputs.
module vga_tile_engine
  import vga_tile_engine_pkg::*;
#(
  parameter int PIXEL_DIV = DEF_PIXEL_DIV,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FPORCH  = DEF_H_FPORCH,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BPORCH  = DEF_H_BPORCH,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FPORCH  = DEF_V_FPORCH,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BPORCH  = DEF_V_BPORCH,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int TILE_SIZE = 40,
  parameter int TILES_X   = 16,
  parameter int TILES_Y   = 12,
  parameter int ADDR_W    = 8,
  parameter int COLOR_W   = 4
) (
  input  logic                 CLOCK_50M,
  input  logic                 RESET_N,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  input  logic                 WR_MODE,
  input  logic [ADDR_W-1:0]    WR_ADDR,
  input  logic                 WR_DATA,
  output logic                 WR_ERR,
  input  logic                 CLR_START,
  output logic                 CLR_BUSY,
  input  logic [ADDR_W-1:0]    CURSOR_X,
  input  logic [ADDR_W-1:0]    CURSOR_Y,
  input  logic [3*COLOR_W-1:0] FG_COLOR,
  input  logic [3*COLOR_W-1:0] BG_COLOR,
  input  logic [3*COLOR_W-1:0] CUR_COLOR,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 VGA_HSYNC,
  output logic                 VGA_VSYNC,
  output logic                 FRAME_START
);

  localparam int TILES = TILES_X * TILES_Y;
  localparam int CW    = $clog2(TILES_X + 1);
  localparam int RW    = $clog2(TILES_Y + 1);
  localparam int SW    = $clog2(TILE_SIZE + 1);
  localparam int PW    = 3 * COLOR_W;

  vid_t            w_vid;
  wr_state_t       r_state;
  logic [TILES-1:0] r_map;
  logic [ADDR_W-1:0] r_clr_idx;
  logic            r_busy;
  logic            r_err;
  logic [SW-1:0]   r_sub_x;
  logic [SW-1:0]   r_sub_y;
  logic [CW-1:0]   r_tcol;
  logic [RW-1:0]   r_trow;
  logic [PW-1:0]   r_rgb;
  logic            r_hs;
  logic            r_vs;
  logic            w_col_out;
  logic            w_row_out;
  logic            w_in_grid;
  logic            w_sub_x_end;
  logic            w_sub_y_end;
  logic            w_edge;
  logic            w_cursor;
  logic            w_fg;
  logic            w_map_bit;
  logic            w_addr_ok;
  logic [ADDR_W-1:0] w_idx;
  logic [PW-1:0]   w_color;

  vga_tile_engine_timing_gen #(
    .PIXEL_DIV (PIXEL_DIV),
    .H_ACTIVE  (H_ACTIVE),
    .H_FPORCH  (H_FPORCH),
    .H_SYNC    (H_SYNC),
    .H_BPORCH  (H_BPORCH),
    .V_ACTIVE  (V_ACTIVE),
    .V_FPORCH  (V_FPORCH),
    .V_SYNC    (V_SYNC),
    .V_BPORCH  (V_BPORCH)
  ) u_timing (
    .i_clk   (CLOCK_50M),
    .i_rst_n (RESET_N),
    .o_vid   (w_vid),
    .o_frame (FRAME_START)
  );

  assign w_col_out   = (r_tcol == CW'(TILES_X));
  assign w_row_out   = (r_trow == RW'(TILES_Y));
  assign w_in_grid   = !w_col_out && !w_row_out;
  assign w_sub_x_end = (r_sub_x == SW'(TILE_SIZE - 1));
  assign w_sub_y_end = (r_sub_y == SW'(TILE_SIZE - 1));

  // Tile position tracks h/v counters; column/row saturate past the grid.
  always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sub_x <= '0;
      r_tcol  <= '0;
      r_sub_y <= '0;
      r_trow  <= '0;
    end else if (w_vid.pix_en) begin
      if (w_vid.h_last) begin
        r_sub_x <= '0;
        r_tcol  <= '0;
        if (w_vid.v_last) begin
          r_sub_y <= '0;
          r_trow  <= '0;
        end else if (w_sub_y_end) begin
          r_sub_y <= '0;
          if (!w_row_out)
            r_trow <= r_trow + 1'b1;
        end else begin
          r_sub_y <= r_sub_y + 1'b1;
        end
      end else if (w_sub_x_end) begin
        r_sub_x <= '0;
        if (!w_col_out)
          r_tcol <= r_tcol + 1'b1;
      end else begin
        r_sub_x <= r_sub_x + 1'b1;
      end
    end
  end

  assign w_idx     = ADDR_W'(int'(r_trow) * TILES_X + int'(r_tcol));
  assign w_map_bit = |(r_map & (TILES'(1) << w_idx));
  assign w_edge    = (r_sub_x == '0) || w_sub_x_end ||
                     (r_sub_y == '0) || w_sub_y_end;
  assign w_cursor  = w_in_grid && w_edge &&
                     (ADDR_W'(r_tcol) == CURSOR_X) &&
                     (ADDR_W'(r_trow) == CURSOR_Y);
  assign w_fg      = w_in_grid && w_map_bit && !w_cursor;

  always_comb begin
    w_color = BG_COLOR;
    unique case (1'b1)
      w_cursor: w_color = CUR_COLOR;
      w_fg:     w_color = FG_COLOR;
      default:  w_color = BG_COLOR;
    endcase
  end

  always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rgb <= '0;
      r_hs  <= !HSYNC_POL;
      r_vs  <= !VSYNC_POL;
    end else if (w_vid.pix_en) begin
      r_rgb <= w_vid.active ? w_color : '0;
      r_hs  <= w_vid.hs_act ? HSYNC_POL : !HSYNC_POL;
      r_vs  <= w_vid.vs_act ? VSYNC_POL : !VSYNC_POL;
    end
  end

  assign w_addr_ok = (32'(WR_ADDR) < TILES);

  // Clear takes priority over a same-cycle write; one tile per cycle.
  always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_map     <= '0;
      r_clr_idx <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (CLR_START) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_idx <= '0;
          end else if (WR_VALID) begin
            if (WR_MODE)
              r_map <= {r_map[TILES-2:0], WR_DATA};
            else if (w_addr_ok)
              r_map <= (r_map & ~(TILES'(1) << WR_ADDR)) |
                       (TILES'(WR_DATA) << WR_ADDR);
            else
              r_err <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_map <= r_map & ~(TILES'(1) << r_clr_idx);
          if (r_clr_idx == ADDR_W'(TILES - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign WR_READY  = !r_busy;
  assign CLR_BUSY  = r_busy;
  assign WR_ERR    = r_err;
  assign VGA_R     = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign VGA_G     = r_rgb[2*COLOR_W-1:COLOR_W];
  assign VGA_B     = r_rgb[COLOR_W-1:0];
  assign VGA_HSYNC = r_hs;
  assign VGA_VSYNC = r_vs;

endmodule

// File: tb/tb_vga_tile_engine.sv
// Scoreboard bench for vga_tile_engine on a shrunken raster:
// a division-based reference model queues expected pixels and control.
module tb_vga_tile_engine;

  localparam int DIV = 2;
  localparam int HA = 40, HF = 4, HSW = 6, HB = 6;
  localparam int VA = 24, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int TS = 5, TX = 6, TY = 4, NT = TX * TY;
  localparam int AW = 5, CWD = 4;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0, wr_mode = 1'b0, wr_data = 1'b0;
  logic clr_start = 1'b0;
  logic [AW-1:0] wr_addr = '0, cur_x = '1, cur_y = '1;
  logic [3*CWD-1:0] fg = 12'hF00, bg = 12'hFFF, cc = 12'h0F0;
  logic wr_ready, wr_err, clr_busy, hs, vs, frame;
  logic [CWD-1:0] vr, vg, vb;

  vga_tile_engine #(
    .PIXEL_DIV(DIV), .H_ACTIVE(HA), .H_FPORCH(HF), .H_SYNC(HSW),
    .H_BPORCH(HB), .V_ACTIVE(VA), .V_FPORCH(VF), .V_SYNC(VSW),
    .V_BPORCH(VB), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .TILE_SIZE(TS), .TILES_X(TX), .TILES_Y(TY),
    .ADDR_W(AW), .COLOR_W(CWD)
  ) dut (
    .CLOCK_50M(clk), .RESET_N(rst_n),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_MODE(wr_mode),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_ERR(wr_err),
    .CLR_START(clr_start), .CLR_BUSY(clr_busy),
    .CURSOR_X(cur_x), .CURSOR_Y(cur_y),
    .FG_COLOR(fg), .BG_COLOR(bg), .CUR_COLOR(cc),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
    .VGA_HSYNC(hs), .VGA_VSYNC(vs), .FRAME_START(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         x;
    int         y;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
  } pix_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic err;
    logic frame;
  } ctl_t;

  pix_t pq[$];
  ctl_t cq[$];
  bit   mmap[NT];
  int   m_div, m_h, m_v, m_idx;
  bit   m_busy;
  int   n_vec = 0, n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic pix_t ref_pixel(int x, int y);
    pix_t p;
    int col, row;
    bit edge_px;
    p.x = x;
    p.y = y;
    p.hs = (x >= HA + HF && x < HA + HF + HSW) ? HPOL : !HPOL;
    p.vs = (y >= VA + VF && y < VA + VF + VSW) ? VPOL : !VPOL;
    p.rgb = '0;
    if (x < HA && y < VA) begin
      col = x / TS;
      row = y / TS;
      edge_px = (x % TS == 0) || (x % TS == TS - 1) ||
                (y % TS == 0) || (y % TS == TS - 1);
      if (col >= TX || row >= TY)
        p.rgb = bg;
      else if (col == int'(cur_x) && row == int'(cur_y) && edge_px)
        p.rgb = cc;
      else
        p.rgb = mmap[row * TX + col] ? fg : bg;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_div = 0; m_h = 0; m_v = 0; m_idx = 0; m_busy = 0;
    foreach (mmap[i]) mmap[i] = 0;
    pq.delete();
    cq.delete();
  endtask

  // Pixel sampled before the map update of this edge takes effect.
  task automatic model_step();
    ctl_t c;
    bit fr;
    fr = 0;
    c.err = 0;
    if (m_div == 0) begin
      pq.push_back(ref_pixel(m_h, m_v));
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
      fr = (m_h == 0 && m_v == 0);
    end
    m_div = (m_div + 1) % DIV;
    if (m_busy) begin
      mmap[m_idx] = 0;
      m_idx++;
      if (m_idx == NT) m_busy = 0;
    end else if (clr_start) begin
      m_busy = 1;
      m_idx = 0;
    end else if (wr_valid) begin
      if (wr_mode) begin
        for (int i = NT - 1; i > 0; i--) mmap[i] = mmap[i-1];
        mmap[0] = wr_data;
      end else if (int'(wr_addr) < NT) begin
        mmap[wr_addr] = wr_data;
      end else begin
        c.err = 1;
      end
    end
    c.busy = m_busy;
    c.ready = !m_busy;
    c.frame = fr;
    cq.push_back(c);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    pix_t p;
    ctl_t c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cq.size() > 0) begin
          c = cq.pop_front();
          check("wr_ready", 32'(wr_ready), 32'(c.ready));
          check("clr_busy", 32'(clr_busy), 32'(c.busy));
          check("wr_err", 32'(wr_err), 32'(c.err));
          check("frame_start", 32'(frame), 32'(c.frame));
        end
        if (pq.size() > 0) begin
          p = pq.pop_front();
          check($sformatf("pixel(%0d,%0d)", p.x, p.y),
                {18'b0, vr, vg, vb, hs, vs},
                {18'b0, p.rgb, p.hs, p.vs});
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame();
    idle(HT * VT * DIV);
  endtask

  task automatic wr(int mode, int addr, int data);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_mode = mode[0];
    wr_addr = addr[AW-1:0];
    wr_data = data[0];
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rgb", {20'b0, vr, vg, vb}, 32'd0);
    check("rst_hsync", 32'(hs), 32'(!HPOL));
    check("rst_vsync", 32'(vs), 32'(!VPOL));
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_err", 32'(wr_err), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, cnt;
    idle(3);
    check_reset_outputs();
    rst_n = 1'b1;
    run_frame();

    wr(0, 8, 1);
    run_frame();

    wr(1, 0, 1);
    wr(1, 0, 0);
    wr(1, 0, 1);
    wr(0, 28, 1);
    @(negedge clk);
    cur_x = 5'd3;
    cur_y = 5'd2;
    run_frame();

    repeat (60) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        wr(($urandom_range(0, 3) == 0) ? 1 : 0,
           $urandom_range(0, 31), $urandom_range(0, 1));
      end else if (op < 8) begin
        idle($urandom_range(1, 40));
      end else begin
        @(negedge clk);
        cur_x = 5'($urandom_range(0, 7));
        cur_y = 5'($urandom_range(0, 5));
        fg = 12'($urandom);
        bg = 12'($urandom);
        cc = 12'($urandom);
      end
    end
    run_frame();

    repeat (NT) wr(1, 0, 1);
    @(negedge clk);
    clr_start = 1'b1;
    wr_valid = 1'b1;
    wr_mode = 1'b0;
    wr_addr = 5'd3;
    wr_data = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      cnt++;
      clr_start = (cnt == 5);
      @(negedge clk);
    end
    clr_start = 1'b0;
    wr_valid = 1'b0;
    check("clr_busy_cycles", 32'(cnt), 32'(NT));
    run_frame();

    idle(HT * DIV * 3 + 37);
    reset_pulse();
    wr(0, 14, 1);
    run_frame();

    repeat (10) wr(1, 0, 1);
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    idle(5);
    reset_pulse();
    run_frame();

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
